// File: rtl/dual_priority_encoder_seq_pkg.sv
// Shared definitions for the sequential dual priority encoder.
package dual_priority_encoder_seq_pkg;

    localparam int N_REQ_DEF   = 12;
    localparam int IDX_W_DEF   = 4;
    localparam int INVALID_IDX = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/dual_priority_encoder_seq_prio.sv
// Combinational highest-set-bit finder: reports the index of the top set bit
// of vec_i, or the invalid index with found_o=0 when vec_i is all zero.
module prio_find_msb
    import dual_priority_encoder_seq_pkg::*;
#(
    parameter int W     = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx_o   = IDX_W'(INVALID_IDX);
        found_o = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_priority_encoder_seq.sv
// Sequential dual priority encoder: captures a request vector and reports the
// two highest pending bits per handshake until the vector is drained.
module dual_priority_encoder_seq
    import dual_priority_encoder_seq_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_vld,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_vld,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid-side data is held stable until that edge.

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d;
    logic [IDX_W-1:0]   second_idx_q, second_idx_d;
    logic               first_vld_q, first_vld_d;
    logic               second_vld_q, second_vld_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   msb1_idx, msb2_idx;
    logic               msb1_found, msb2_found;
    logic [N_REQ-1:0]   msb1_mask, masked_pending;
    logic [N_REQ-1:0]   clr_first, clr_second, remaining;

    prio_find_msb #(.W(N_REQ), .IDX_W(IDX_W)) u_find_first (
        .vec_i   (pending_q),
        .idx_o   (msb1_idx),
        .found_o (msb1_found)
    );

    prio_find_msb #(.W(N_REQ), .IDX_W(IDX_W)) u_find_second (
        .vec_i   (masked_pending),
        .idx_o   (msb2_idx),
        .found_o (msb2_found)
    );

    always_comb begin
        msb1_mask      = msb1_found ? (N_REQ'(1) << msb1_idx) : '0;
        masked_pending = pending_q & ~msb1_mask;
        clr_first      = first_vld_q ? (N_REQ'(1) << first_idx_q) : '0;
        clr_second     = second_vld_q ? (N_REQ'(1) << second_idx_q) : '0;
        remaining      = pending_q & ~clr_first & ~clr_second;
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        first_idx_d  = first_idx_q;
        first_vld_d  = first_vld_q;
        second_idx_d = second_idx_q;
        second_vld_d = second_vld_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pending_d = req_in;
                    if (|req_in) state_d = CALC;
                    else         done_d  = 1'b1;
                end
            end
            CALC: begin
                first_idx_d  = msb1_idx;
                first_vld_d  = msb1_found;
                second_idx_d = msb2_idx;
                second_vld_d = msb2_found;
                state_d      = PRESENT;
            end
            PRESENT: begin
                // Output fields fall back to the invalid index while recomputing.
                if (out_ready) begin
                    pending_d    = remaining;
                    first_idx_d  = IDX_W'(INVALID_IDX);
                    first_vld_d  = 1'b0;
                    second_idx_d = IDX_W'(INVALID_IDX);
                    second_vld_d = 1'b0;
                    if (|remaining) begin
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            first_idx_q  <= IDX_W'(INVALID_IDX);
            first_vld_q  <= 1'b0;
            second_idx_q <= IDX_W'(INVALID_IDX);
            second_vld_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            first_idx_q  <= first_idx_d;
            first_vld_q  <= first_vld_d;
            second_idx_q <= second_idx_d;
            second_vld_q <= second_vld_d;
            done_q       <= done_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign out_valid  = (state_q == PRESENT);
    assign first_idx  = first_idx_q;
    assign first_vld  = first_vld_q;
    assign second_idx = second_idx_q;
    assign second_vld = second_vld_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule
